iterative_alu: RTL and testbench

- Execution-side consumer of the 4-bit alu_control code produced by the ALU decoder.
- Accepts an operation and two 32-bit operands through a valid/ready handshake, executes it, and returns the result plus a zero flag through a second valid/ready handshake.
- Logic and arithmetic ops complete in 1 cycle.
- Shifts run serially, one bit position per cycle, to save area in the multi-cycle core variant.

---
 rtl/iterative_alu.sv | 178 +++++++++++++++++
 tb/tb_iterative_alu.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/iterative_alu.sv
// Iterative ALU: single-cycle logic/arithmetic ops and a bit-serial shifter,
// with valid/ready handshakes on both the request and the result side.
module iterative_alu #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_control,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal_op
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_SLL  = 4'd4;
  localparam logic [3:0] OP_SRL  = 4'd5;
  localparam logic [3:0] OP_SRA  = 4'd6;
  localparam logic [3:0] OP_XOR  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;

  localparam logic [XLEN-1:0] ONE = {{(XLEN-1){1'b0}}, 1'b1};

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            zero_q, zero_d;
  logic            illegal_q, illegal_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [3:0]      op_q, op_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] eval_s;
  logic [XLEN-1:0] shifted_s;

  function automatic logic is_shift(input logic [3:0] op);
    is_shift = (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

  function automatic logic is_illegal(input logic [3:0] op);
    is_illegal = (op > OP_SLTU);
  endfunction

  // Single-cycle operations; shifts and illegal codes are handled elsewhere.
  function automatic logic [XLEN-1:0] alu_eval(input logic [3:0]      op,
                                               input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
    case (op)
      OP_ADD:  alu_eval = a + b;
      OP_SUB:  alu_eval = a - b;
      OP_AND:  alu_eval = a & b;
      OP_OR:   alu_eval = a | b;
      OP_XOR:  alu_eval = a ^ b;
      OP_SLT:  alu_eval = ($signed(a) < $signed(b)) ? ONE : {XLEN{1'b0}};
      OP_SLTU: alu_eval = (a < b) ? ONE : {XLEN{1'b0}};
      default: alu_eval = {XLEN{1'b0}};
    endcase
  endfunction

  function automatic logic [XLEN-1:0] shift_step(input logic [3:0]      op,
                                                 input logic [XLEN-1:0] v);
    case (op)
      OP_SLL:  shift_step = {v[XLEN-2:0], 1'b0};
      OP_SRL:  shift_step = {1'b0, v[XLEN-1:1]};
      OP_SRA:  shift_step = {v[XLEN-1], v[XLEN-1:1]};
      default: shift_step = v;
    endcase
  endfunction

  assign eval_s    = alu_eval(alu_control, src_a, src_b);
  // result_q doubles as the shift working register while in SHIFT
  assign shifted_s = shift_step(op_q, result_q);

  // Next-state and datapath selection for the handshake FSM.
  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d = alu_control;
          if (is_shift(alu_control)) begin
            result_d  = src_a;
            illegal_d = 1'b0;
            cnt_d     = src_b[4:0];
            if (src_b[4:0] == 5'd0) begin
              state_d = DONE;
              zero_d  = (src_a == {XLEN{1'b0}});
            end else begin
              state_d = SHIFT;
              zero_d  = 1'b0;
            end
          end else if (is_illegal(alu_control)) begin
            state_d   = DONE;
            result_d  = {XLEN{1'b0}};
            zero_d    = 1'b1;
            illegal_d = 1'b1;
          end else begin
            state_d   = DONE;
            result_d  = eval_s;
            zero_d    = (eval_s == {XLEN{1'b0}});
            illegal_d = 1'b0;
          end
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        result_d = shifted_s;
        cnt_d    = cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          state_d = DONE;
          zero_d  = (shifted_s == {XLEN{1'b0}});
        end else begin
          state_d = SHIFT;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      result_q    <= {XLEN{1'b0}};
      zero_q      <= 1'b0;
      illegal_q   <= 1'b0;
      cnt_q       <= 5'd0;
      op_q        <= 4'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      illegal_q   <= illegal_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign result     = result_q;
  assign zero       = zero_q;
  assign illegal_op = illegal_q;

endmodule

// File: tb/tb_iterative_alu.sv
// Self-checking bench for iterative_alu: directed vector table, handshake
// sequences and randomized ops checked against a behavioural model.
module tb_iterative_alu;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_control;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        illegal_op;

  int checks = 0;
  int errors = 0;

  iterative_alu #(.XLEN(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alu_control(alu_control),
    .src_a      (src_a),
    .src_b      (src_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .zero       (zero),
    .illegal_op (illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_res;
    logic        exp_zero;
    logic        exp_ill;
    int          exp_lat;
    int          hold;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference: whole-word arithmetic straight from the operation definitions.
  function automatic logic [31:0] ref_result(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    int sh;
    sh = int'(b[4:0]);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a << sh;
      4'd5:    return a >> sh;
      4'd6:    return $unsigned($signed(a) >>> sh);
      4'd7:    return a ^ b;
      4'd8:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9:    return (a < b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int ref_latency(input logic [3:0] op, input logic [31:0] b);
    if (op >= 4'd4 && op <= 4'd6 && b[4:0] != 5'd0) return int'(b[4:0]) + 1;
    return 1;
  endfunction

  // Issue one op, measure latency, check outputs, hold, then release.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res,
                        input logic exp_zero, input logic exp_ill, input int exp_lat,
                        input int hold);
    int lat;
    @(negedge clk);
    chk({tag, ".in_ready_before"}, {31'd0, in_ready}, 32'd1);
    in_valid    = 1'b1;
    alu_control = op;
    src_a       = a;
    src_b       = b;
    @(posedge clk);
    #1;
    in_valid    = 1'b0;
    alu_control = 4'($urandom_range(0, 15));
    src_a       = $urandom;
    src_b       = $urandom;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      src_a = $urandom;
      src_b = $urandom;
    end
    chk({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, ".result"}, result, exp_res);
    chk({tag, ".zero"}, {31'd0, zero}, {31'd0, exp_zero});
    chk({tag, ".illegal"}, {31'd0, illegal_op}, {31'd0, exp_ill});
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      chk({tag, ".hold_valid"}, {31'd0, out_valid}, 32'd1);
      chk({tag, ".hold_result"}, result, exp_res);
      chk({tag, ".hold_zero"}, {31'd0, zero}, {31'd0, exp_zero});
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, ".release_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, ".release_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  vec_t vecs[13];

  initial begin
    logic [31:0] exp_q[$];
    logic [31:0] e;
    logic [3:0]  rop;
    logic [31:0] ra, rb;
    int          accepts;

    vecs[0]  = '{4'd0,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1,  3};
    vecs[1]  = '{4'd8,  32'h8000_0000, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 1,  0};
    vecs[2]  = '{4'd9,  32'h8000_0000, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1,  0};
    vecs[3]  = '{4'd1,  32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0, 1'b0, 1,  0};
    vecs[4]  = '{4'd6,  32'h8000_0000, 32'hFFFF_FFE4, 32'hF800_0000, 1'b0, 1'b0, 5,  2};
    vecs[5]  = '{4'd5,  32'h8000_0000, 32'hFFFF_FFE4, 32'h0800_0000, 1'b0, 1'b0, 5,  0};
    vecs[6]  = '{4'd4,  32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 1'b0, 1'b0, 32, 0};
    vecs[7]  = '{4'd4,  32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 1'b0, 1'b0, 1,  0};
    vecs[8]  = '{4'd12, 32'h1234_5678, 32'h0000_0003, 32'h0000_0000, 1'b1, 1'b1, 1,  2};
    vecs[9]  = '{4'd2,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0, 1,  0};
    vecs[10] = '{4'd3,  32'h0000_00F0, 32'h0F00_0000, 32'h0F00_00F0, 1'b0, 1'b0, 1,  0};
    vecs[11] = '{4'd7,  32'hAAAA_AAAA, 32'hFFFF_FFFF, 32'h5555_5555, 1'b0, 1'b0, 1,  0};
    vecs[12] = '{4'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b1, 1,  0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    alu_control = 4'd0; src_a = 32'd0; src_b = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset.out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset.result", result, 32'd0);
    chk("reset.zero", {31'd0, zero}, 32'd0);
    chk("reset.illegal", {31'd0, illegal_op}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_res,
             vecs[i].exp_zero, vecs[i].exp_ill, vecs[i].exp_lat, vecs[i].hold);
    end

    // Back-to-back: in_valid and out_ready held high, one accept per 2 cycles.
    accepts = 0;
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (c > 0) @(negedge clk);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("b2b.unexpected_valid", {31'd0, out_valid}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("b2b.result", result, e);
        end
      end
      alu_control = 4'($urandom_range(0, 3));
      src_a       = $urandom;
      src_b       = $urandom;
      if (in_ready) begin
        accepts++;
        exp_q.push_back(ref_result(alu_control, src_a, src_b));
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    chk("b2b.accepts", 32'(accepts), 32'd10);
    chk("b2b.drained", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of a 20-position shift.
    @(negedge clk);
    in_valid = 1'b1; alu_control = 4'd4; src_a = 32'h0000_0001; src_b = 32'd20;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("midrst.busy", {31'd0, in_ready}, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst.out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst.result", result, 32'd0);
    chk("midrst.in_ready", {31'd0, in_ready}, 32'd1);
    run_op("midrst.and", 4'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0, 1, 0);

    // Randomized ops against the behavioural model.
    for (int r = 0; r < 40; r++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = $urandom;
      rb  = $urandom;
      if (r % 4 == 0) ra = 32'd0;
      if (r % 5 == 0) rb = 32'($urandom_range(0, 3));
      e = ref_result(rop, ra, rb);
      run_op($sformatf("rand%0d", r), rop, ra, rb, e, (e == 32'd0), (rop > 4'd9),
             ref_latency(rop, rb), r % 3);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
